// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
// Module   : deserializer
// Function : narrow-to-wide valid/ready width converter, first beat in LSBs.
//            Define DESERIALIZER_FLUSH_EN to add the in_flush early-close port.
// Revision : 1.0
// ============================================================================
module deserializer #(
  parameter int INLOGBITS  = 5,
  parameter int OUTLOGBITS = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [(1<<INLOGBITS)-1:0]   in_data,
`ifdef DESERIALIZER_FLUSH_EN
  input  logic                        in_flush,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [(1<<OUTLOGBITS)-1:0]  out_data
);

  localparam int INWIDTH    = 1 << INLOGBITS;
  localparam int OUTWIDTH   = 1 << OUTLOGBITS;
  localparam int LOGBITDIFF = OUTLOGBITS - INLOGBITS;
  localparam int CNTW       = (LOGBITDIFF > 0) ? LOGBITDIFF : 1;
  localparam int NBEATS     = 1 << CNTW;
  // The top lane is never parked: the final beat goes straight to out_data.
  localparam int ACCWIDTH   = OUTWIDTH - INWIDTH;
  localparam logic [CNTW-1:0] c_MAXCNT = CNTW'(NBEATS - 1);

  generate
    if (OUTLOGBITS <= INLOGBITS) begin : g_bad_widths
      $error("deserializer: OUTLOGBITS must be greater than INLOGBITS");
    end
  endgenerate

  logic [CNTW-1:0]     r_cnt;
  logic [ACCWIDTH-1:0] r_acc;
  logic                r_out_valid;
  logic [OUTWIDTH-1:0] r_out_data;

  logic                w_flush;
  logic                w_final;
  logic                w_accept;
  logic                w_complete;
  logic [OUTWIDTH-1:0] w_word;

`ifdef DESERIALIZER_FLUSH_EN
  assign w_flush = in_flush;

  // Early-closed word: filled lanes from acc, current lane from in_data, rest zero.
  generate
    for (genvar i = 0; i < NBEATS; i++) begin : g_lane
      localparam logic [CNTW-1:0] c_LANE = CNTW'(i);
      if (i < NBEATS - 1) begin : g_low
        assign w_word[i*INWIDTH +: INWIDTH] =
          (c_LANE < r_cnt)  ? r_acc[i*INWIDTH +: INWIDTH] :
          (c_LANE == r_cnt) ? in_data : '0;
      end else begin : g_top
        assign w_word[i*INWIDTH +: INWIDTH] = (r_cnt == c_LANE) ? in_data : '0;
      end
    end
  endgenerate
`else
  assign w_flush = 1'b0;
  assign w_word  = {in_data, r_acc};
`endif

  assign w_final    = (r_cnt == c_MAXCNT) || w_flush;
  assign in_ready   = !reset && (!w_final || !r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && w_final;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        for (int i = 0; i < NBEATS - 1; i++) begin
          if (r_cnt == CNTW'(i)) begin
            r_acc[i*INWIDTH +: INWIDTH] <= in_data;
          end
        end
      end
    end
  end

  // A completing word takes priority over a drain, so the slot never bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_complete) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

`default_nettype wire
